// File: rtl/vga_scope_renderer_if.sv
// Signal bundle between the scope renderer, the trace-sample generator and the VGA DAC.
// master = renderer side; slave = generator/DAC side.
interface vga_scope_renderer_if;
    logic [9:0] Val_CY;
    logic       blank_n;
    logic       Vsyn;
    logic       Hsyn;
    logic       VGA_HS;
    logic       VGA_VS;
    logic       VGA_BLANK_N;
    logic [7:0] VGA_R;
    logic [7:0] VGA_G;
    logic [7:0] VGA_B;
    logic       frame_tick;

    modport master (
        input  Val_CY,
        output blank_n, Vsyn, Hsyn, VGA_HS, VGA_VS, VGA_BLANK_N,
        output VGA_R, VGA_G, VGA_B, frame_tick
    );

    modport slave (
        output Val_CY,
        input  blank_n, Vsyn, Hsyn, VGA_HS, VGA_VS, VGA_BLANK_N,
        input  VGA_R, VGA_G, VGA_B, frame_tick
    );
endinterface

// File: rtl/vga_scope_renderer.sv
// VGA timing generator plus waveform rasteriser: draws a vertically-filled trace from per-column
// samples over a graticule, with sync and colour aligned two cycles behind the stage-0 flags.
module vga_scope_renderer #(
    parameter int          H_ACTIVE  = 640,
    parameter int          H_FP      = 16,
    parameter int          H_SYNC    = 96,
    parameter int          H_BP      = 48,
    parameter int          V_ACTIVE  = 480,
    parameter int          V_FP      = 10,
    parameter int          V_SYNC    = 2,
    parameter int          V_BP      = 33,
    parameter int          GRID_X    = 64,
    parameter int          GRID_Y    = 60,
    parameter logic [23:0] TRACE_RGB = 24'hFFFF00,
    parameter logic [23:0] GRID_RGB  = 24'h404040,
    parameter logic [23:0] AXIS_RGB  = 24'h808080,
    parameter logic [23:0] BG_RGB    = 24'h000000
) (
    input  logic                 VGA_clk,
    input  logic                 reset,
    vga_scope_renderer_if.master scope
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] COL_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] ROW_LAST = 10'(V_ACTIVE - 1);
    localparam logic [9:0] AXIS_ROW = 10'(V_ACTIVE / 2 - 1);
    localparam logic [9:0] GX_LAST  = 10'(GRID_X - 1);
    localparam logic [9:0] GY_LAST  = 10'(GRID_Y - 1);
    localparam logic [9:0] WRAP_MIN = 10'd768;

    // Stage 0: raster counters and grid sub-counters
    logic [9:0] h_cnt, v_cnt, col_mod, row_mod;
    logic [9:0] s0_row;
    logic       s0_col0, s0_grid, s0_axis;

    // Stage 1: pixel attributes aligned with the generator's Val_CY
    logic [9:0] s1_row;
    logic       s1_blank, s1_hs, s1_vs, s1_col0, s1_grid, s1_axis;

    // Trace history and the combinational rasteriser feeding the output register
    logic [9:0]  cur_y, y_new, seg_start, lo, hi;
    logic        trace_hit;
    logic [23:0] pixel_rgb;

    // NOTE: every register below uses <= so all stages sample the previous cycle's values.
    always_ff @(posedge VGA_clk) begin
        if (reset) begin
            h_cnt            <= '0;
            v_cnt            <= '0;
            col_mod          <= '0;
            row_mod          <= '0;
            scope.blank_n    <= 1'b0;
            scope.Hsyn       <= 1'b1;
            scope.Vsyn       <= 1'b1;
            scope.frame_tick <= 1'b0;
            s0_row           <= '0;
            s0_col0          <= 1'b0;
            s0_grid          <= 1'b0;
            s0_axis          <= 1'b0;
        end else begin
            scope.blank_n    <= (h_cnt < H_VIS) && (v_cnt < V_VIS);
            scope.Hsyn       <= !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
            scope.Vsyn       <= !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
            scope.frame_tick <= (h_cnt == '0) && (v_cnt == '0);
            s0_row           <= v_cnt;
            s0_col0          <= (h_cnt == '0);
            s0_grid          <= (col_mod == '0) || (row_mod == '0) ||
                                (h_cnt == COL_LAST) || (v_cnt == ROW_LAST);
            s0_axis          <= (v_cnt == AXIS_ROW);

            if (h_cnt == H_LAST) begin
                h_cnt   <= '0;
                col_mod <= '0;
                if (v_cnt == V_LAST) begin
                    v_cnt   <= '0;
                    row_mod <= '0;
                end else begin
                    v_cnt   <= v_cnt + 10'd1;
                    row_mod <= (row_mod == GY_LAST) ? '0 : row_mod + 10'd1;
                end
            end else begin
                h_cnt   <= h_cnt + 10'd1;
                col_mod <= (col_mod == GX_LAST) ? '0 : col_mod + 10'd1;
            end
        end
    end

    always_ff @(posedge VGA_clk) begin
        if (reset) begin
            s1_blank <= 1'b0;
            s1_hs    <= 1'b1;
            s1_vs    <= 1'b1;
            s1_row   <= '0;
            s1_col0  <= 1'b0;
            s1_grid  <= 1'b0;
            s1_axis  <= 1'b0;
        end else begin
            s1_blank <= scope.blank_n;
            s1_hs    <= scope.Hsyn;
            s1_vs    <= scope.Vsyn;
            s1_row   <= s0_row;
            s1_col0  <= s0_col0;
            s1_grid  <= s0_grid;
            s1_axis  <= s0_axis;
        end
    end

    // Column 0 starts a fresh segment so the previous line's last sample never joins in.
    // NOTE: each always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        y_new = scope.Val_CY;
        if (scope.Val_CY >= WRAP_MIN) begin
            y_new = '0;
        end else if (scope.Val_CY > ROW_LAST) begin
            y_new = ROW_LAST;
        end
        seg_start = s1_col0 ? y_new : cur_y;
        lo        = (seg_start < y_new) ? seg_start : y_new;
        hi        = (seg_start < y_new) ? y_new : seg_start;
        trace_hit = (s1_row >= lo) && (s1_row <= hi);

        pixel_rgb = BG_RGB;
        if (!s1_blank) begin
            pixel_rgb = '0;
        end else if (trace_hit) begin
            pixel_rgb = TRACE_RGB;
        end else if (s1_axis) begin
            pixel_rgb = AXIS_RGB;
        end else if (s1_grid) begin
            pixel_rgb = GRID_RGB;
        end
    end

    always_ff @(posedge VGA_clk) begin
        if (reset) begin
            cur_y             <= '0;
            scope.VGA_HS      <= 1'b1;
            scope.VGA_VS      <= 1'b1;
            scope.VGA_BLANK_N <= 1'b0;
            scope.VGA_R       <= '0;
            scope.VGA_G       <= '0;
            scope.VGA_B       <= '0;
        end else begin
            if (s1_blank) begin
                cur_y <= y_new;
            end
            scope.VGA_HS      <= s1_hs;
            scope.VGA_VS      <= s1_vs;
            scope.VGA_BLANK_N <= s1_blank;
            {scope.VGA_R, scope.VGA_G, scope.VGA_B} <= pixel_rgb;
        end
    end
endmodule

// File: tb/tb_vga_scope_renderer.sv
// Bench for vga_scope_renderer: line timing on a full-size instance, per-pixel scoreboard and
// spot-pixel table on a narrow-line instance that keeps whole frames short.
module tb_vga_scope_renderer;
    localparam int SH_ACT = 32;
    localparam int SH_FP  = 4;
    localparam int SH_SYN = 8;
    localparam int SH_BP  = 4;
    localparam int SH_TOT = SH_ACT + SH_FP + SH_SYN + SH_BP;
    localparam int V_TOT  = 525;
    localparam int SGX    = 8;
    localparam int SGY    = 60;
    localparam int FRAME  = SH_TOT * V_TOT;

    localparam logic [23:0] C_TRACE = 24'hFFFF00;
    localparam logic [23:0] C_GRID  = 24'h404040;
    localparam logic [23:0] C_AXIS  = 24'h808080;
    localparam logic [23:0] C_BG    = 24'h000000;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    always #20 clk = ~clk;

    vga_scope_renderer_if bus_a ();
    vga_scope_renderer_if bus_b ();

    vga_scope_renderer u_full (
        .VGA_clk (clk),
        .reset   (rst_a),
        .scope   (bus_a)
    );

    vga_scope_renderer #(
        .H_ACTIVE (SH_ACT), .H_FP (SH_FP), .H_SYNC (SH_SYN), .H_BP (SH_BP),
        .GRID_X   (SGX),    .GRID_Y (SGY)
    ) u_small (
        .VGA_clk (clk),
        .reset   (rst_b),
        .scope   (bus_b)
    );

    typedef struct {
        int   k;
        logic bl, hs, vhs, vbl, ft;
    } t1_t;

    typedef struct {
        int          fid;
        int          row;
        int          col;
        logic [23:0] rgb;
    } spot_t;

    typedef struct {
        int          fid;
        int          h;
        int          v;
        logic        bl, hs, vs;
        logic [23:0] rgb;
    } sb_t;

    int n_pass  = 0;
    int n_total = 0;

    t1_t   t1_tab [$];
    spot_t spots  [$];
    sb_t   sbq    [$];
    logic [23:0] pix [2][480][SH_ACT];

    int         m_h, m_v, ph, pv, cyc, last_tick, n_periods, vlow;
    bit         have_prev;
    logic [9:0] mcur;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [9:0] clampy(input logic [9:0] v);
        if (v < 10'd480) return v;
        if (v < 10'd768) return 10'd479;
        return 10'd0;
    endfunction

    // mode 0: constant 100; mode 1: per-line mix of the interesting sample patterns
    function automatic logic [9:0] val_for(input int mode, input int h, input int v);
        if (mode == 0) return 10'd100;
        if (v == 239) return 10'd239;
        if (v >= 200 && v <= 280) return (h % 2 == 0) ? 10'd200 : 10'd280;
        if (v == 0) return 10'd1000;
        if (v == 479) return 10'd600;
        if (v == 310) return (h < 16) ? 10'd600 : 10'd1000;
        return 10'd100;
    endfunction

    function automatic logic [23:0] colour(input int h, input int v, input int a, input int b);
        int lo, hi;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        if (v >= lo && v <= hi) return C_TRACE;
        if (v == 239) return C_AXIS;
        if (h % SGX == 0 || v % SGY == 0 || h == SH_ACT - 1 || v == 479) return C_GRID;
        return C_BG;
    endfunction

    task automatic reset_small(input int n);
        rst_b = 1'b1;
        repeat (n) @(negedge clk);
        check("small_reset_outputs",
              {bus_b.blank_n, bus_b.Hsyn, bus_b.Vsyn, bus_b.frame_tick, bus_b.VGA_HS,
               bus_b.VGA_VS, bus_b.VGA_BLANK_N, bus_b.VGA_R, bus_b.VGA_G, bus_b.VGA_B},
              {7'b0110110, 24'h0});
        rst_b     = 1'b0;
        sbq.delete();
        m_h       = 0;
        m_v       = 0;
        have_prev = 1'b0;
        last_tick = -1;
        mcur      = '0;
    endtask

    task automatic step(input int mode, input int fid);
        sb_t        e;
        logic [9:0] y, p;
        @(negedge clk);
        check($sformatf("stage0 h=%0d v=%0d", m_h, m_v),
              {bus_b.blank_n, bus_b.Hsyn, bus_b.Vsyn, bus_b.frame_tick},
              {(m_h < SH_ACT && m_v < 480), !(m_h >= SH_ACT + SH_FP && m_h < SH_ACT + SH_FP + SH_SYN),
               !(m_v >= 490 && m_v < 492), (m_h == 0 && m_v == 0)});
        if (!bus_b.Vsyn) vlow++;
        if (bus_b.frame_tick) begin
            if (last_tick >= 0) begin
                check("frame_tick_period", 64'(cyc - last_tick), 64'(FRAME));
                n_periods++;
            end
            last_tick = cyc;
        end
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check($sformatf("out h=%0d v=%0d", e.h, e.v),
                  {bus_b.VGA_BLANK_N, bus_b.VGA_HS, bus_b.VGA_VS, bus_b.VGA_R, bus_b.VGA_G, bus_b.VGA_B},
                  {e.bl, e.hs, e.vs, e.rgb});
            if (e.fid >= 0 && e.bl) pix[e.fid][e.v][e.h] = {bus_b.VGA_R, bus_b.VGA_G, bus_b.VGA_B};
        end
        if (have_prev) begin
            bus_b.Val_CY = val_for(mode, ph, pv);
            e.fid = fid;
            e.h   = ph;
            e.v   = pv;
            e.bl  = (ph < SH_ACT) && (pv < 480);
            e.hs  = !(ph >= SH_ACT + SH_FP && ph < SH_ACT + SH_FP + SH_SYN);
            e.vs  = !(pv >= 490 && pv < 492);
            e.rgb = 24'h0;
            if (e.bl) begin
                y     = clampy(bus_b.Val_CY);
                p     = (ph == 0) ? y : mcur;
                mcur  = y;
                e.rgb = colour(ph, pv, int'(p), int'(y));
            end
            sbq.push_back(e);
        end
        ph        = m_h;
        pv        = m_v;
        have_prev = 1'b1;
        cyc++;
        m_h++;
        if (m_h == SH_TOT) begin
            m_h = 0;
            m_v = (m_v == V_TOT - 1) ? 0 : m_v + 1;
        end
    endtask

    initial begin
        // full-size line timing: k = cycles since the first visible pixel at stage 0
        t1_tab.push_back('{0,   1, 1, 1, 0, 1});
        t1_tab.push_back('{1,   1, 1, 1, 0, 0});
        t1_tab.push_back('{2,   1, 1, 1, 1, 0});
        t1_tab.push_back('{639, 1, 1, 1, 1, 0});
        t1_tab.push_back('{640, 0, 1, 1, 1, 0});
        t1_tab.push_back('{642, 0, 1, 1, 0, 0});
        t1_tab.push_back('{655, 0, 1, 1, 0, 0});
        t1_tab.push_back('{656, 0, 0, 1, 0, 0});
        t1_tab.push_back('{658, 0, 0, 0, 0, 0});
        t1_tab.push_back('{751, 0, 0, 0, 0, 0});
        t1_tab.push_back('{752, 0, 1, 0, 0, 0});
        t1_tab.push_back('{754, 0, 1, 1, 0, 0});
        t1_tab.push_back('{799, 0, 1, 1, 0, 0});
        t1_tab.push_back('{800, 1, 1, 1, 0, 0});
        t1_tab.push_back('{802, 1, 1, 1, 1, 0});

        // frame 0: mixed sample patterns; frame 1: constant 100 after the mid-frame reset
        spots.push_back('{0, 0,   5,  C_TRACE});
        spots.push_back('{0, 479, 5,  C_TRACE});
        spots.push_back('{0, 239, 5,  C_TRACE});
        spots.push_back('{0, 200, 0,  C_TRACE});
        spots.push_back('{0, 250, 0,  C_GRID});
        spots.push_back('{0, 250, 1,  C_TRACE});
        spots.push_back('{0, 250, 3,  C_TRACE});
        spots.push_back('{0, 100, 5,  C_TRACE});
        spots.push_back('{0, 60,  5,  C_GRID});
        spots.push_back('{0, 310, 16, C_TRACE});
        spots.push_back('{0, 310, 17, C_BG});
        spots.push_back('{0, 310, 3,  C_BG});
        spots.push_back('{0, 301, 3,  C_BG});
        spots.push_back('{1, 100, 0,  C_TRACE});
        spots.push_back('{1, 100, 31, C_TRACE});
        spots.push_back('{1, 239, 5,  C_AXIS});
        spots.push_back('{1, 239, 8,  C_AXIS});
        spots.push_back('{1, 60,  5,  C_GRID});
        spots.push_back('{1, 61,  8,  C_GRID});
        spots.push_back('{1, 61,  31, C_GRID});
        spots.push_back('{1, 479, 3,  C_GRID});
        spots.push_back('{1, 120, 4,  C_GRID});
        spots.push_back('{1, 0,   3,  C_GRID});
        spots.push_back('{1, 101, 3,  C_BG});
        spots.push_back('{1, 99,  3,  C_BG});

        rst_a        = 1'b1;
        rst_b        = 1'b1;
        bus_a.Val_CY = 10'd0;
        bus_b.Val_CY = 10'd0;
        cyc          = 0;
        n_periods    = 0;
        vlow         = 0;

        repeat (5) @(negedge clk);
        check("full_reset_outputs",
              {bus_a.blank_n, bus_a.Hsyn, bus_a.Vsyn, bus_a.frame_tick, bus_a.VGA_HS,
               bus_a.VGA_VS, bus_a.VGA_BLANK_N, bus_a.VGA_R, bus_a.VGA_G, bus_a.VGA_B},
              {7'b0110110, 24'h0});
        rst_a = 1'b0;
        for (int k = 0; k <= 802; k++) begin
            @(negedge clk);
            foreach (t1_tab[i]) begin
                if (t1_tab[i].k == k) begin
                    check($sformatf("line_timing k=%0d", k),
                          {bus_a.blank_n, bus_a.Hsyn, bus_a.VGA_HS, bus_a.VGA_BLANK_N, bus_a.frame_tick},
                          {t1_tab[i].bl, t1_tab[i].hs, t1_tab[i].vhs, t1_tab[i].vbl, t1_tab[i].ft});
                end
            end
        end

        reset_small(5);
        for (int i = 0; i < FRAME; i++) step(1, 0);
        check("vsync_low_cycles", 64'(vlow), 64'(2 * SH_TOT));

        for (int i = 0; i < FRAME; i++) begin
            if (m_h == 20 && m_v == 50) break;
            step(0, -1);
        end
        check("midframe_reset_position", {32'(m_h), 32'(m_v)}, {32'd20, 32'd50});
        reset_small(1);
        for (int i = 0; i < FRAME + 3; i++) step(0, (i < FRAME) ? 1 : -1);
        check("frame_tick_periods_seen", 64'(n_periods), 64'd2);

        foreach (spots[i]) begin
            check($sformatf("spot f=%0d row=%0d col=%0d", spots[i].fid, spots[i].row, spots[i].col),
                  64'(pix[spots[i].fid][spots[i].row][spots[i].col]), 64'(spots[i].rgb));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
